ntt_bram_stream_reader: RTL and testbench

//  Drains one N-point polynomial from the 256x16 true-dual-port coefficient BRAM (read-only use of one port)

---
 rtl/ntt_bram_stream_reader_if.sv | 30 +++
 rtl/ntt_bram_stream_reader.sv | 158 +++++++++++++++
 tb/tb_ntt_bram_stream_reader.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_bram_stream_reader_if.sv
// Handshake bundle between the coefficient reader,
// the BRAM read port and the downstream stream.
interface ntt_bram_stream_reader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) ();
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_rdata;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_index;
  logic              m_last;

  modport master (
    input  start, abort, bram_rdata, m_ready,
    output busy, done, bram_addr,
    output m_valid, m_data, m_index, m_last
  );

  modport slave (
    output start, abort, bram_rdata, m_ready,
    input  busy, done, bram_addr,
    input  m_valid, m_data, m_index, m_last
  );
endinterface

// File: rtl/ntt_bram_stream_reader.sv
// Streams one N-point polynomial out of the coefficient
// BRAM through a 2-entry skid FIFO, optionally bit-reversed.
module ntt_bram_stream_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int BITREV = 0
) (
  input logic clk,
  input logic rst,
  ntt_bram_stream_reader_if.master io_bus
);
  localparam logic [ADDR_W:0] L_LAST =
    {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] L_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W:0]   r_iss_cnt;
  logic [ADDR_W:0]   r_out_cnt;
  logic              r_pend;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [1:0]        r_cnt;
  logic [DATA_W-1:0] r_d0;
  logic [DATA_W-1:0] r_d1;
  logic [ADDR_W-1:0] r_i0;
  logic [ADDR_W-1:0] r_i1;
  logic              r_busy;
  logic              r_done;

  logic              w_valid;
  logic              w_pop;
  logic              w_issue;
  logic              w_final;
  logic [ADDR_W-1:0] w_rev;
  logic [ADDR_W-1:0] w_addr;

  always_comb begin
    w_rev = '0;
    for (int b = 0; b < ADDR_W; b++)
      w_rev[b] = r_iss_cnt[ADDR_W-1-b];
  end

  assign w_addr  = (BITREV != 0) ? w_rev
                 : r_iss_cnt[ADDR_W-1:0];
  assign w_valid = (r_cnt != 2'd0);
  assign w_pop   = w_valid & io_bus.m_ready;
  assign w_final = w_pop & (r_out_cnt == L_LAST);

  // Credit rule: data in FIFO plus read in flight never exceeds 2.
  assign w_issue = (r_state == S_RUN)
                 & ~r_iss_cnt[ADDR_W]
                 & (({1'b0, r_cnt} + {2'b0, r_pend})
                    <= (3'd1 + {2'b0, w_pop}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_iss_cnt   <= '0;
      r_out_cnt   <= '0;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_cnt       <= 2'd0;
      r_d0        <= '0;
      r_d1        <= '0;
      r_i0        <= '0;
      r_i1        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_pend <= 1'b0;
          r_cnt  <= 2'd0;
          if (io_bus.start && !io_bus.abort) begin
            r_state   <= S_RUN;
            r_busy    <= 1'b1;
            r_iss_cnt <= '0;
            r_out_cnt <= '0;
          end
        end
        S_RUN: begin
          if (io_bus.abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_pend  <= 1'b0;
            r_cnt   <= 2'd0;
          end else begin
            r_pend <= w_issue;
            if (w_issue) begin
              r_pend_addr <= w_addr;
              r_iss_cnt   <= r_iss_cnt + L_ONE;
            end
            case ({r_pend, w_pop})
              2'b10: begin
                if (r_cnt == 2'd0) begin
                  r_d0 <= io_bus.bram_rdata;
                  r_i0 <= r_pend_addr;
                end else begin
                  r_d1 <= io_bus.bram_rdata;
                  r_i1 <= r_pend_addr;
                end
                r_cnt <= r_cnt + 2'd1;
              end
              2'b01: begin
                r_d0  <= r_d1;
                r_i0  <= r_i1;
                r_cnt <= r_cnt - 2'd1;
              end
              2'b11: begin
                if (r_cnt == 2'd1) begin
                  r_d0 <= io_bus.bram_rdata;
                  r_i0 <= r_pend_addr;
                end else begin
                  r_d0 <= r_d1;
                  r_i0 <= r_i1;
                  r_d1 <= io_bus.bram_rdata;
                  r_i1 <= r_pend_addr;
                end
              end
              default: ;
            endcase
            if (w_pop)
              r_out_cnt <= r_out_cnt + L_ONE;
            if (w_final) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_pend  <= 1'b0;
          r_cnt   <= 2'd0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.busy      = r_busy;
  assign io_bus.done      = r_done;
  assign io_bus.bram_addr = w_addr;
  assign io_bus.m_valid   = w_valid;
  assign io_bus.m_data    = r_d0;
  assign io_bus.m_index   = r_i0;
  assign io_bus.m_last    = w_valid
                          & (r_out_cnt == L_LAST);
endmodule

// File: tb/tb_ntt_bram_stream_reader.sv
// Directed bench: in-order and bit-reversed readout,
// backpressure, abort, ignored start and async reset.
module tb_ntt_bram_stream_reader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ntt_bram_stream_reader_if u_if0 ();
  ntt_bram_stream_reader_if u_if1 ();

  ntt_bram_stream_reader #(.BITREV(0)) u_dut0 (
    .clk    (clk),
    .rst    (rst),
    .io_bus (u_if0)
  );
  ntt_bram_stream_reader #(.BITREV(1)) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .io_bus (u_if1)
  );

  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];

  always @(posedge clk) begin
    u_if0.bram_rdata <= mem0[u_if0.bram_addr];
    u_if1.bram_rdata <= mem1[u_if1.bram_addr];
  end

  int tests = 0;
  int fails = 0;
  int cap_d [2][256];
  int cap_i [2][256];

  typedef struct {
    int sel;
    int mode;
    bit poke;
    int exp_lat;
  } run_vec_t;

  typedef struct {
    int sel;
    int k;
    int exp_idx;
    int exp_dat;
  } spot_t;

  task automatic chk(input string nm,
                     input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic int brev8(input int k);
    int r = 0;
    for (int b = 0; b < 8; b++)
      if (k[b]) r |= (1 << (7 - b));
    return r;
  endfunction

  function automatic int exp_idx(input int s,
                                 input int k);
    return (s != 0) ? brev8(k) : k;
  endfunction

  function automatic int exp_dat(input int s,
                                 input int k);
    return (s != 0) ? brev8(k) : (k * 3) % 3329;
  endfunction

  function automatic bit g_v(input int s);
    return (s != 0) ? u_if1.m_valid : u_if0.m_valid;
  endfunction
  function automatic bit g_last(input int s);
    return (s != 0) ? u_if1.m_last : u_if0.m_last;
  endfunction
  function automatic bit g_done(input int s);
    return (s != 0) ? u_if1.done : u_if0.done;
  endfunction
  function automatic bit g_busy(input int s);
    return (s != 0) ? u_if1.busy : u_if0.busy;
  endfunction
  function automatic int g_d(input int s);
    return (s != 0) ? int'(u_if1.m_data)
                    : int'(u_if0.m_data);
  endfunction
  function automatic int g_i(input int s);
    return (s != 0) ? int'(u_if1.m_index)
                    : int'(u_if0.m_index);
  endfunction

  task automatic set_start(input int s, input bit v);
    if (s != 0) u_if1.start = v;
    else u_if0.start = v;
  endtask
  task automatic set_abort(input int s, input bit v);
    if (s != 0) u_if1.abort = v;
    else u_if0.abort = v;
  endtask
  task automatic set_ready(input bit v);
    u_if0.m_ready = v;
    u_if1.m_ready = v;
  endtask

  function automatic int mism(input int s);
    int n = 0;
    for (int k = 0; k < 256; k++)
      if (cap_d[s][k] != exp_dat(s, k) ||
          cap_i[s][k] != exp_idx(s, k)) n++;
    return n;
  endfunction

  // mode 0: ready always; mode 1: random plus 20-cycle stall
  task automatic run(
    input int s, input int mode, input bit poke,
    input int abort_at, input int rst_at,
    output int nw, output int lat, output int nd,
    output int gaps, output int stab,
    output int lerr, output int post);
    int  c = 0;
    int  burst = 0;
    int  pd = 0;
    int  pi = 0;
    bit  pv = 0;
    bit  pr = 0;
    bit  v;
    bit  rdy;
    bit  fin = 0;
    nw = 0; lat = -1; nd = 0; gaps = 0;
    stab = 0; lerr = 0; post = 0;
    cap_d[s] = '{default: -1};
    cap_i[s] = '{default: -1};
    set_ready(1'b0);
    set_start(s, 1'b1);
    @(negedge clk);
    set_start(s, 1'b0);
    while (c < 4000 && !fin) begin
      v = g_v(s);
      if (v && lat < 0) lat = c;
      if (pv && !pr && (!v || g_d(s) != pd ||
                        g_i(s) != pi)) stab++;
      if (mode == 0 && lat >= 0 && nw < 256 && !v)
        gaps++;
      if (g_done(s)) begin
        nd++;
        if (nw != 256) lerr++;
        if (poke) set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
        post = int'(g_busy(s)) + int'(g_v(s))
             + int'(g_done(s));
        fin = 1;
      end else begin
        if (poke) set_start(s, c == 50);
        if (mode == 0) rdy = 1'b1;
        else if (nw == 100 && burst < 20) begin
          rdy = 1'b0;
          burst++;
        end else rdy = 1'(($urandom % 2));
        if (v && nw == abort_at) begin
          set_abort(s, 1'b1);
          set_ready(1'b0);
          @(negedge clk);
          set_abort(s, 1'b0);
          return;
        end
        if (v && nw == rst_at) begin
          #2 rst = 1'b1;
          #1;
          post = int'(g_busy(s)) + int'(g_v(s))
               + int'(g_done(s));
          return;
        end
        if (v && (g_last(s) != (nw == 255))) lerr++;
        if (v && rdy && nw < 256) begin
          cap_d[s][nw] = g_d(s);
          cap_i[s][nw] = g_i(s);
          nw++;
        end
        pv = v; pr = rdy;
        pd = g_d(s); pi = g_i(s);
        set_ready(rdy);
        @(negedge clk);
        c++;
      end
    end
    if (!fin) $display("FAIL run_timeout: sel %0d", s);
  endtask

  run_vec_t rv [4];
  spot_t    sv [8];
  int nw, lat, nd, gp, st, le, po;

  initial begin
    rv[0] = '{sel: 0, mode: 0, poke: 0, exp_lat: 2};
    rv[1] = '{sel: 1, mode: 0, poke: 0, exp_lat: 2};
    rv[2] = '{sel: 0, mode: 1, poke: 0, exp_lat: 2};
    rv[3] = '{sel: 0, mode: 0, poke: 1, exp_lat: 2};
    sv[0] = '{sel: 0, k: 0,   exp_idx: 0,   exp_dat: 0};
    sv[1] = '{sel: 0, k: 1,   exp_idx: 1,   exp_dat: 3};
    sv[2] = '{sel: 0, k: 100, exp_idx: 100, exp_dat: 300};
    sv[3] = '{sel: 0, k: 255, exp_idx: 255, exp_dat: 765};
    sv[4] = '{sel: 1, k: 1,   exp_idx: 128, exp_dat: 128};
    sv[5] = '{sel: 1, k: 2,   exp_idx: 64,  exp_dat: 64};
    sv[6] = '{sel: 1, k: 3,   exp_idx: 192, exp_dat: 192};
    sv[7] = '{sel: 1, k: 255, exp_idx: 255, exp_dat: 255};
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 16'((i * 3) % 3329);
      mem1[i] = 16'(i);
    end
    u_if0.start = 0; u_if0.abort = 0;
    u_if1.start = 0; u_if1.abort = 0;
    set_ready(1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy",  int'(u_if0.busy), 0);
    chk("rst_done",  int'(u_if0.done), 0);
    chk("rst_valid", int'(u_if0.m_valid), 0);
    chk("rst_last",  int'(u_if0.m_last), 0);
    chk("rst_data",  int'(u_if0.m_data), 0);
    chk("rst_index", int'(u_if0.m_index), 0);
    chk("rst_addr",  int'(u_if0.bram_addr), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 4; r++) begin
      run(rv[r].sel, rv[r].mode, rv[r].poke, -1, -1,
          nw, lat, nd, gp, st, le, po);
      chk($sformatf("run%0d_words", r), nw, 256);
      chk($sformatf("run%0d_lat", r), lat,
          rv[r].exp_lat);
      chk($sformatf("run%0d_done", r), nd, 1);
      chk($sformatf("run%0d_gaps", r), gp, 0);
      chk($sformatf("run%0d_stable", r), st, 0);
      chk($sformatf("run%0d_last", r), le, 0);
      chk($sformatf("run%0d_post", r), po, 0);
      chk($sformatf("run%0d_data", r),
          mism(rv[r].sel), 0);
      @(negedge clk);
    end

    for (int j = 0; j < 8; j++) begin
      chk($sformatf("spot%0d_idx", j),
          cap_i[sv[j].sel][sv[j].k], sv[j].exp_idx);
      chk($sformatf("spot%0d_dat", j),
          cap_d[sv[j].sel][sv[j].k], sv[j].exp_dat);
    end

    u_if0.start = 1; u_if0.abort = 1;
    @(negedge clk);
    u_if0.start = 0; u_if0.abort = 0;
    chk("sa_busy", int'(u_if0.busy), 0);
    @(negedge clk);
    chk("sa_busy2",  int'(u_if0.busy), 0);
    chk("sa_valid2", int'(u_if0.m_valid), 0);

    run(0, 0, 0, 37, -1, nw, lat, nd, gp, st, le, po);
    chk("abort_at", nw, 37);
    chk("abort_valid", int'(u_if0.m_valid), 0);
    chk("abort_busy",  int'(u_if0.busy), 0);
    chk("abort_done",  int'(u_if0.done), 0);
    @(negedge clk);
    chk("abort_done2", int'(u_if0.done), 0);
    chk("abort_valid2", int'(u_if0.m_valid), 0);
    run(0, 0, 0, -1, -1, nw, lat, nd, gp, st, le, po);
    chk("replay_words", nw, 256);
    chk("replay_first", cap_i[0][0], 0);
    chk("replay_data", mism(0), 0);
    chk("replay_done", nd, 1);
    @(negedge clk);

    run(0, 0, 0, -1, 60, nw, lat, nd, gp, st, le, po);
    chk("arst_outs", po, 0);
    chk("arst_at", nw, 60);
    @(negedge clk);
    chk("arst_valid", int'(u_if0.m_valid), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_idle", int'(u_if0.busy), 0);
    run(0, 0, 0, -1, -1, nw, lat, nd, gp, st, le, po);
    chk("arst_words", nw, 256);
    chk("arst_data", mism(0), 0);
    chk("arst_done", nd, 1);
    chk("arst_lat", lat, 2);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end
endmodule
